// File: rtl/ictlb_miss_seq.sv
// Instruction L1 TLB miss sequencer: one outstanding L2 TLB request,
// fill delivery, and snoop invalidate/ack serialised against the miss.
module ictlb_miss_seq #(
    parameter int VPN_W = 24,
    parameter int PPN_W = 20,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             miss_valid,
    output logic             miss_retry,
    input  logic [VPN_W-1:0] miss_vpn,

    output logic             l1tlbtol2tlb_req_valid,
    input  logic             l1tlbtol2tlb_req_retry,
    output logic [VPN_W-1:0] l1tlbtol2tlb_req_vpn,
    output logic [ID_W-1:0]  l1tlbtol2tlb_req_id,

    input  logic             l2tlbtol1tlb_ack_valid,
    output logic             l2tlbtol1tlb_ack_retry,
    input  logic [ID_W-1:0]  l2tlbtol1tlb_ack_id,
    input  logic [PPN_W-1:0] l2tlbtol1tlb_ack_ppn,
    input  logic             l2tlbtol1tlb_ack_fault,

    output logic             fill_valid,
    input  logic             fill_retry,
    output logic [VPN_W-1:0] fill_vpn,
    output logic [PPN_W-1:0] fill_ppn,
    output logic             fill_fault,

    input  logic             l2tlbtol1tlb_snoop_valid,
    output logic             l2tlbtol1tlb_snoop_retry,
    input  logic [VPN_W-1:0] l2tlbtol1tlb_snoop_vpn,

    output logic             inv_valid,
    input  logic             inv_retry,
    output logic [VPN_W-1:0] inv_vpn,

    output logic             l1tlbtol2tlb_sack_valid,
    input  logic             l1tlbtol2tlb_sack_retry,
    output logic [VPN_W-1:0] l1tlbtol2tlb_sack_vpn,

    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL,
        S_SNP_INV,
        S_SNP_ACK
    } state_t;

    state_t             state, state_d;
    state_t             ret_state, ret_d;
    logic [VPN_W-1:0]   vpn_q, vpn_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    id_ctr, ctr_d;
    logic               kill, kill_d;
    logic [PPN_W-1:0]   ppn_q, ppn_d;
    logic               fault_q, fault_d;
    logic [VPN_W-1:0]   snp_q, snp_d;

    logic               ack_match;

    assign ack_match = (l2tlbtol1tlb_ack_id == id_q);

    always_comb begin
        state_d    = state;
        ret_d      = ret_state;
        vpn_d      = vpn_q;
        id_d       = id_q;
        ctr_d      = id_ctr;
        kill_d     = kill;
        ppn_d      = ppn_q;
        fault_d    = fault_q;
        snp_d      = snp_q;
        miss_retry = 1'b1;
        l2tlbtol1tlb_snoop_retry = 1'b1;
        l2tlbtol1tlb_ack_retry   = 1'b1;

        unique case (state)
            S_IDLE: begin
                l2tlbtol1tlb_snoop_retry = 1'b0;
                l2tlbtol1tlb_ack_retry   = 1'b0;
                miss_retry = l2tlbtol1tlb_snoop_valid;
                if (l2tlbtol1tlb_snoop_valid) begin
                    snp_d   = l2tlbtol1tlb_snoop_vpn;
                    ret_d   = S_IDLE;
                    state_d = S_SNP_INV;
                end else if (miss_valid) begin
                    vpn_d   = miss_vpn;
                    id_d    = id_ctr;
                    ctr_d   = id_ctr + ID_W'(1);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Late acks (post reset or kill) drain here as stale.
                l2tlbtol1tlb_ack_retry = 1'b0;
                if (!l1tlbtol2tlb_req_retry) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                l2tlbtol1tlb_snoop_retry = 1'b0;
                l2tlbtol1tlb_ack_retry   = l2tlbtol1tlb_snoop_valid;
                if (l2tlbtol1tlb_snoop_valid) begin
                    snp_d   = l2tlbtol1tlb_snoop_vpn;
                    ret_d   = S_WAIT;
                    state_d = S_SNP_INV;
                    if (l2tlbtol1tlb_snoop_vpn == vpn_q) begin
                        kill_d = 1'b1;
                    end
                end else if (l2tlbtol1tlb_ack_valid && ack_match) begin
                    if (kill) begin
                        // Translation may predate the invalidate: refetch.
                        kill_d  = 1'b0;
                        id_d    = id_ctr;
                        ctr_d   = id_ctr + ID_W'(1);
                        state_d = S_REQ;
                    end else begin
                        ppn_d   = l2tlbtol1tlb_ack_ppn;
                        fault_d = l2tlbtol1tlb_ack_fault;
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (!fill_retry) begin
                    state_d = S_IDLE;
                end
            end
            S_SNP_INV: begin
                if (!inv_retry) begin
                    state_d = S_SNP_ACK;
                end
            end
            S_SNP_ACK: begin
                if (!l1tlbtol2tlb_sack_retry) begin
                    state_d = ret_state;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            vpn_q     <= '0;
            id_q      <= '0;
            id_ctr    <= '0;
            kill      <= 1'b0;
            ppn_q     <= '0;
            fault_q   <= 1'b0;
            snp_q     <= '0;
        end else begin
            state     <= state_d;
            ret_state <= ret_d;
            vpn_q     <= vpn_d;
            id_q      <= id_d;
            id_ctr    <= ctr_d;
            kill      <= kill_d;
            ppn_q     <= ppn_d;
            fault_q   <= fault_d;
            snp_q     <= snp_d;
        end
    end

    // Valids decode straight from the state flop, payloads from holding regs.
    assign l1tlbtol2tlb_req_valid  = (state == S_REQ);
    assign l1tlbtol2tlb_req_vpn    = vpn_q;
    assign l1tlbtol2tlb_req_id     = id_q;

    assign fill_valid              = (state == S_FILL);
    assign fill_vpn                = vpn_q;
    assign fill_ppn                = ppn_q;
    assign fill_fault              = fault_q;

    assign inv_valid               = (state == S_SNP_INV);
    assign inv_vpn                 = snp_q;

    assign l1tlbtol2tlb_sack_valid = (state == S_SNP_ACK);
    assign l1tlbtol2tlb_sack_vpn   = snp_q;

    assign busy                    = (state != S_IDLE);

endmodule

// File: doc/ictlb_miss_seq.md
Name: ictlb_miss_seq

Overview:
- Miss sequencer for the instruction L1 TLB.
- On a TLB miss it issues one request to the L2 TLB, waits for the matching ack, and delivers a fill to the TLB array.
- It serialises L2 TLB snoops against the outstanding miss: invalidate, then snoop-ack.
- Sits between the ictlb lookup/array and the L2 TLB ports; one miss is outstanding at a time.

Parameters:
- VPN_W, 24, virtual page number width.
- PPN_W, 20, physical page number width.
- ID_W, 3, request ID width; the ID counter wraps modulo 2^ID_W.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- miss_valid  in  1  lookup missed.
- miss_retry  out  1  miss not accepted this cycle.
- miss_vpn  in  VPN_W  missing VPN.
- l1tlbtol2tlb_req_valid  out  1  request to L2 TLB.
- l1tlbtol2tlb_req_retry  in  1  L2 backpressure.
- l1tlbtol2tlb_req_vpn  out  VPN_W  requested VPN.
- l1tlbtol2tlb_req_id  out  ID_W  request tag.
- l2tlbtol1tlb_ack_valid  in  1  L2 reply.
- l2tlbtol1tlb_ack_retry  out  1  reply not accepted.
- l2tlbtol1tlb_ack_id  in  ID_W  reply tag.
- l2tlbtol1tlb_ack_ppn  in  PPN_W  translation.
- l2tlbtol1tlb_ack_fault  in  1  page fault.
- fill_valid  out  1  write entry into the TLB array.
- fill_retry  in  1  array busy.
- fill_vpn  out  VPN_W  fill tag.
- fill_ppn  out  PPN_W  fill data.
- fill_fault  out  1  fault entry.
- l2tlbtol1tlb_snoop_valid  in  1  snoop/invalidate from L2.
- l2tlbtol1tlb_snoop_retry  out  1  snoop not accepted.
- l2tlbtol1tlb_snoop_vpn  in  VPN_W  snooped VPN.
- inv_valid  out  1  invalidate array entry; also drives the L1 cmd notify.
- inv_retry  in  1  backpressure.
- inv_vpn  out  VPN_W  VPN to invalidate.
- l1tlbtol2tlb_sack_valid  out  1  snoop ack to L2.
- l1tlbtol2tlb_sack_retry  in  1  backpressure.
- l1tlbtol2tlb_sack_vpn  out  VPN_W  acked VPN.
- busy  out  1  state != IDLE.

Behaviour:
- Handshake
  - A transfer occurs when valid=1 and retry=0 in the same cycle.
  - Every output valid and its payload are registered and held stable while retry=1.
- Reset
  - Synchronous, active-high; clk is the only clock.
  - Reset state: IDLE. All *_valid=0, busy=0, id_ctr=0, kill=0, ret_state=IDLE.
  - Reset aborts any operation in flight; no partial fill or sack is emitted.
- States: IDLE, REQ, WAIT, FILL, SNP_INV, SNP_ACK.
- IDLE
  - A snoop has priority: snoop_retry=0, and miss_retry=1 whenever snoop_valid=1.
  - Otherwise miss_retry=0.
  - Miss accept: latch vpn and id=id_ctr, increment id_ctr, go to REQ. req_valid=1 from the next cycle.
- REQ
  - Hold req_valid until accepted, then go to WAIT.
  - miss_retry=1, snoop_retry=1.
- WAIT
  - snoop_retry=0 and ack_retry=0. If a snoop and an ack arrive in the same cycle, the snoop wins and ack_retry=1 that cycle.
  - Ack with id != latched id: consumed and dropped (stale).
  - Matching ack with kill=0: latch ppn and fault, go to FILL.
  - Matching ack with kill=1: clear kill, assign a new id from id_ctr (incremented), go to REQ. This reissues the request with the same vpn.
- FILL
  - fill_valid=1 until accepted, then go to IDLE.
  - ack_retry=1, snoop_retry=1.
- Snoop accept (IDLE or WAIT)
  - Latch snoop vpn, set ret_state to the current state, go to SNP_INV.
  - If in WAIT and the snoop vpn equals the miss vpn, set kill=1.
- SNP_INV: inv_valid=1 until accepted, then go to SNP_ACK.
- SNP_ACK: sack_valid=1 until accepted, then go to ret_state.
- While in SNP_INV or SNP_ACK: miss_retry=1, ack_retry=1, snoop_retry=1.
- Acks arriving in IDLE or REQ: ack_retry=0, consumed and dropped as stale. This prevents deadlock after a reset or a kill.
- miss_retry=1 in every state except IDLE.
- Minimum latencies:
  - Miss accept to req_valid: 1 cycle.
  - Ack accept to fill_valid: 1 cycle.
  - Snoop accept to inv_valid: 1 cycle; inv accept to sack_valid: 1 cycle.
- ID wrap: id_ctr goes 7 to 0 with no special handling.

Test Plan:
- Basic miss:
  - Stimulus: miss vpn=0x00ABC; L2 acks id=0, ppn=0x12345, fault=0 two cycles after the request is accepted.
  - Response: req_valid one cycle after miss accept with vpn=0x00ABC, id=0. Fill (vpn=0x00ABC, ppn=0x12345, fault=0) one cycle after the ack. Then busy=0.
- Backpressure:
  - Stimulus: req_retry=1 for 5 cycles, then fill_retry=1 for 3 cycles.
  - Response: req_valid, vpn and id held stable through the req stall; fill held through the fill stall; exactly one of each transfer.
- Snoop on the miss VPN during WAIT:
  - Stimulus: miss vpn=0x00010; snoop vpn=0x00010 while in WAIT; then ack id=0.
  - Response: inv followed by sack for 0x00010. The id=0 ack is dropped with no fill. A reissued request goes out with id=1; its ack produces the fill.
- Stale ack and ID wrap:
  - Stimulus: 8 back-to-back misses; inject an ack with a wrong id during WAIT.
  - Response: the wrong-id ack is consumed with no fill. IDs run 0..7 then wrap to 0 on the 9th miss.
- Simultaneous events:
  - Stimulus: miss and snoop asserted in the same IDLE cycle.
  - Response: snoop accepted and miss_retry=1; the miss is accepted after sack completes.
- Mid-operation reset:
  - Stimulus: assert reset in WAIT; afterwards the L2 sends an ack with id=0.
  - Response: all valids 0 and busy=0. The late ack is accepted (ack_retry=0) and dropped; no fill.
